dual_issue_stage: RTL and testbench

Issue stage sitting directly upstream of the register-file/forwarding stage. It accepts an in-order pair of decoded instructions (slot0 older, slot1 younger). It routes each to the even or odd pipe and holds back instructions with RAW, WAW or structural hazards, using a per-register latency scoreboard. Its registered outputs are the per-pipe instruction bundles consumed by the RF/FU stage.

---
 rtl/dual_issue_stage.sv | 208 ++++++++++++++++++++
 tb/tb_dual_issue_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_stage.sv
// Dual-issue stage: routes an in-order instruction pair to even/odd pipes,
// holding back RAW, WAW and structural hazards with a latency scoreboard.
module dual_issue_stage #(
   parameter int unsigned FWD_SLACK = 1,
   parameter logic [6:0]  NOP_ID    = 7'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   input  logic        in_slot_v_0,
   input  logic        in_slot_v_1,
   input  logic [31:0] in_full_instr_0,
   input  logic [31:0] in_full_instr_1,
   input  logic [6:0]  in_instr_id_0,
   input  logic [6:0]  in_instr_id_1,
   input  logic        in_pipe_0,
   input  logic        in_pipe_1,
   input  logic [2:0]  in_unit_id_0,
   input  logic [2:0]  in_unit_id_1,
   input  logic [3:0]  in_latency_0,
   input  logic [3:0]  in_latency_1,
   input  logic        in_reg_wr_0,
   input  logic        in_reg_wr_1,
   input  logic [6:0]  in_reg_dst_0,
   input  logic [6:0]  in_reg_dst_1,
   input  logic [6:0]  in_ra_0,
   input  logic [6:0]  in_rb_0,
   input  logic [6:0]  in_rc_0,
   input  logic [6:0]  in_ra_1,
   input  logic [6:0]  in_rb_1,
   input  logic [6:0]  in_rc_1,
   input  logic [2:0]  in_src_use_0,
   input  logic [2:0]  in_src_use_1,
   output logic [31:0] out_even_full_instr,
   output logic [6:0]  out_even_instr_id,
   output logic [2:0]  out_even_unit_id,
   output logic [3:0]  out_even_latency,
   output logic        out_even_reg_wr,
   output logic [6:0]  out_even_reg_dst,
   output logic [6:0]  out_even_ra_addr,
   output logic [6:0]  out_even_rb_addr,
   output logic [6:0]  out_even_rc_addr,
   output logic [31:0] out_odd_full_instr,
   output logic [6:0]  out_odd_instr_id,
   output logic [2:0]  out_odd_unit_id,
   output logic [3:0]  out_odd_latency,
   output logic        out_odd_reg_wr,
   output logic [6:0]  out_odd_reg_dst,
   output logic [6:0]  out_odd_ra_addr,
   output logic [6:0]  out_odd_rb_addr,
   output logic [6:0]  out_odd_rc_addr,
   output logic [15:0] stall_count
);

   typedef enum logic {PAIR, SLOT1_ONLY} state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [6:0]  id;
      logic [2:0]  unit;
      logic [3:0]  lat;
      logic        wr;
      logic [6:0]  dst;
      logic [6:0]  ra;
      logic [6:0]  rb;
      logic [6:0]  rc;
   } bundle_t;

   localparam logic [3:0] SLACK = 4'(FWD_SLACK);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q [128];
   logic [3:0]  cnt_d [128];
   bundle_t     even_q, even_d, odd_q, odd_d;
   bundle_t     b0, b1, nop_b;
   logic [15:0] stall_q, stall_d;
   logic        clr0, clr1, raw01, pair_ok;
   logic        iss0, iss1, done0, done1, go;

   always_comb begin
      b0 = '{in_full_instr_0, in_instr_id_0, in_unit_id_0, in_latency_0,
             in_reg_wr_0, in_reg_dst_0, in_ra_0, in_rb_0, in_rc_0};
      b1 = '{in_full_instr_1, in_instr_id_1, in_unit_id_1, in_latency_1,
             in_reg_wr_1, in_reg_dst_1, in_ra_1, in_rb_1, in_rc_1};
      nop_b = '0;
      nop_b.id = NOP_ID;
   end

   // Scoreboard-only hazards: source forwarding readiness plus WAW ordering
   always_comb begin
      clr0 = (!in_src_use_0[2] || cnt_q[in_ra_0] <= SLACK) &&
             (!in_src_use_0[1] || cnt_q[in_rb_0] <= SLACK) &&
             (!in_src_use_0[0] || cnt_q[in_rc_0] <= SLACK) &&
             (!in_reg_wr_0 || cnt_q[in_reg_dst_0] <= in_latency_0);
      clr1 = (!in_src_use_1[2] || cnt_q[in_ra_1] <= SLACK) &&
             (!in_src_use_1[1] || cnt_q[in_rb_1] <= SLACK) &&
             (!in_src_use_1[0] || cnt_q[in_rc_1] <= SLACK) &&
             (!in_reg_wr_1 || cnt_q[in_reg_dst_1] <= in_latency_1);
      raw01 = in_reg_wr_0 &&
              ((in_src_use_1[2] && in_ra_1 == in_reg_dst_0) ||
               (in_src_use_1[1] && in_rb_1 == in_reg_dst_0) ||
               (in_src_use_1[0] && in_rc_1 == in_reg_dst_0));
      pair_ok = !in_slot_v_0 ||
                ((in_pipe_1 != in_pipe_0) && !raw01 &&
                 !(in_reg_wr_0 && in_reg_wr_1 &&
                   in_reg_dst_0 == in_reg_dst_1));
   end

   always_comb begin
      go       = in_valid && !flush;
      iss0     = 1'b0;
      iss1     = 1'b0;
      done0    = 1'b0;
      done1    = 1'b0;
      in_ready = 1'b0;
      state_d  = state_q;
      if (go) begin
         unique case (state_q)
            PAIR: begin
               iss0     = in_slot_v_0 && clr0;
               done0    = !in_slot_v_0 || clr0;
               iss1     = done0 && in_slot_v_1 && clr1 && pair_ok;
               done1    = !in_slot_v_1 || iss1;
               in_ready = done0 && done1;
               state_d  = (done0 && !done1) ? SLOT1_ONLY : PAIR;
            end
            SLOT1_ONLY: begin
               iss1     = in_slot_v_1 && clr1;
               done1    = !in_slot_v_1 || clr1;
               in_ready = done1;
               state_d  = done1 ? PAIR : SLOT1_ONLY;
            end
         endcase
      end
      if (flush) begin
         in_ready = 1'b1;
         state_d  = PAIR;
      end
   end

   always_comb begin
      even_d = nop_b;
      odd_d  = nop_b;
      if (iss0) begin
         if (in_pipe_0) odd_d = b0;
         else           even_d = b0;
      end
      if (iss1) begin
         if (in_pipe_1) odd_d = b1;
         else           even_d = b1;
      end
   end

   // A fresh load wins over the per-cycle decrement of that entry
   always_comb begin
      for (int i = 0; i < 128; i++) begin
         cnt_d[i] = (cnt_q[i] != 4'd0) ? cnt_q[i] - 4'd1 : 4'd0;
      end
      if (iss0 && in_reg_wr_0) cnt_d[in_reg_dst_0] = in_latency_0;
      if (iss1 && in_reg_wr_1) cnt_d[in_reg_dst_1] = in_latency_1;
   end

   always_comb begin
      stall_d = stall_q;
      if (in_valid && !in_ready && !flush && stall_q != 16'hFFFF) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= PAIR;
         cnt_q   <= '{default: 4'd0};
         even_q  <= nop_b;
         odd_q   <= nop_b;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         even_q  <= even_d;
         odd_q   <= odd_d;
         stall_q <= stall_d;
      end
   end

   assign out_even_full_instr = even_q.instr;
   assign out_even_instr_id   = even_q.id;
   assign out_even_unit_id    = even_q.unit;
   assign out_even_latency    = even_q.lat;
   assign out_even_reg_wr     = even_q.wr;
   assign out_even_reg_dst    = even_q.dst;
   assign out_even_ra_addr    = even_q.ra;
   assign out_even_rb_addr    = even_q.rb;
   assign out_even_rc_addr    = even_q.rc;
   assign out_odd_full_instr  = odd_q.instr;
   assign out_odd_instr_id    = odd_q.id;
   assign out_odd_unit_id     = odd_q.unit;
   assign out_odd_latency     = odd_q.lat;
   assign out_odd_reg_wr      = odd_q.wr;
   assign out_odd_reg_dst     = odd_q.dst;
   assign out_odd_ra_addr     = odd_q.ra;
   assign out_odd_rb_addr     = odd_q.rb;
   assign out_odd_rc_addr     = odd_q.rc;
   assign stall_count         = stall_q;

endmodule

// File: tb/tb_dual_issue_stage.sv
// Directed bench for dual_issue_stage: pair routing, hazards, flush, reset.
module tb_dual_issue_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, flush;
   logic        in_slot_v_0, in_slot_v_1;
   logic [31:0] in_full_instr_0, in_full_instr_1;
   logic [6:0]  in_instr_id_0, in_instr_id_1;
   logic        in_pipe_0, in_pipe_1;
   logic [2:0]  in_unit_id_0, in_unit_id_1;
   logic [3:0]  in_latency_0, in_latency_1;
   logic        in_reg_wr_0, in_reg_wr_1;
   logic [6:0]  in_reg_dst_0, in_reg_dst_1;
   logic [6:0]  in_ra_0, in_rb_0, in_rc_0;
   logic [6:0]  in_ra_1, in_rb_1, in_rc_1;
   logic [2:0]  in_src_use_0, in_src_use_1;
   logic [31:0] out_even_full_instr, out_odd_full_instr;
   logic [6:0]  out_even_instr_id, out_odd_instr_id;
   logic [2:0]  out_even_unit_id, out_odd_unit_id;
   logic [3:0]  out_even_latency, out_odd_latency;
   logic        out_even_reg_wr, out_odd_reg_wr;
   logic [6:0]  out_even_reg_dst, out_odd_reg_dst;
   logic [6:0]  out_even_ra_addr, out_even_rb_addr, out_even_rc_addr;
   logic [6:0]  out_odd_ra_addr, out_odd_rb_addr, out_odd_rc_addr;
   logic [15:0] stall_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dual_issue_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush),
      .in_slot_v_0(in_slot_v_0), .in_slot_v_1(in_slot_v_1),
      .in_full_instr_0(in_full_instr_0), .in_full_instr_1(in_full_instr_1),
      .in_instr_id_0(in_instr_id_0), .in_instr_id_1(in_instr_id_1),
      .in_pipe_0(in_pipe_0), .in_pipe_1(in_pipe_1),
      .in_unit_id_0(in_unit_id_0), .in_unit_id_1(in_unit_id_1),
      .in_latency_0(in_latency_0), .in_latency_1(in_latency_1),
      .in_reg_wr_0(in_reg_wr_0), .in_reg_wr_1(in_reg_wr_1),
      .in_reg_dst_0(in_reg_dst_0), .in_reg_dst_1(in_reg_dst_1),
      .in_ra_0(in_ra_0), .in_rb_0(in_rb_0), .in_rc_0(in_rc_0),
      .in_ra_1(in_ra_1), .in_rb_1(in_rb_1), .in_rc_1(in_rc_1),
      .in_src_use_0(in_src_use_0), .in_src_use_1(in_src_use_1),
      .out_even_full_instr(out_even_full_instr),
      .out_even_instr_id(out_even_instr_id),
      .out_even_unit_id(out_even_unit_id),
      .out_even_latency(out_even_latency),
      .out_even_reg_wr(out_even_reg_wr),
      .out_even_reg_dst(out_even_reg_dst),
      .out_even_ra_addr(out_even_ra_addr),
      .out_even_rb_addr(out_even_rb_addr),
      .out_even_rc_addr(out_even_rc_addr),
      .out_odd_full_instr(out_odd_full_instr),
      .out_odd_instr_id(out_odd_instr_id),
      .out_odd_unit_id(out_odd_unit_id),
      .out_odd_latency(out_odd_latency),
      .out_odd_reg_wr(out_odd_reg_wr),
      .out_odd_reg_dst(out_odd_reg_dst),
      .out_odd_ra_addr(out_odd_ra_addr),
      .out_odd_rb_addr(out_odd_rb_addr),
      .out_odd_rc_addr(out_odd_rc_addr),
      .stall_count(stall_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic slot(input int s, input logic v, input logic pipe,
                       input logic [6:0] id, input logic [3:0] lat,
                       input logic wr, input logic [6:0] dst,
                       input logic [6:0] ra, input logic [6:0] rb,
                       input logic [2:0] use_, input logic [31:0] word);
      if (s == 0) begin
         in_slot_v_0 = v; in_pipe_0 = pipe; in_instr_id_0 = id;
         in_latency_0 = lat; in_reg_wr_0 = wr; in_reg_dst_0 = dst;
         in_ra_0 = ra; in_rb_0 = rb; in_rc_0 = 7'd0;
         in_src_use_0 = use_; in_full_instr_0 = word; in_unit_id_0 = 3'd1;
      end else begin
         in_slot_v_1 = v; in_pipe_1 = pipe; in_instr_id_1 = id;
         in_latency_1 = lat; in_reg_wr_1 = wr; in_reg_dst_1 = dst;
         in_ra_1 = ra; in_rb_1 = rb; in_rc_1 = 7'd0;
         in_src_use_1 = use_; in_full_instr_1 = word; in_unit_id_1 = 3'd2;
      end
   endtask

   task automatic chk_nop(input string tag, input logic odd);
      if (odd) begin
         chk({tag, "_odd_id"}, 32'(out_odd_instr_id), 32'd0);
         chk({tag, "_odd_wr"}, 32'(out_odd_reg_wr), 32'd0);
      end else begin
         chk({tag, "_even_id"}, 32'(out_even_instr_id), 32'd0);
         chk({tag, "_even_wr"}, 32'(out_even_reg_wr), 32'd0);
      end
   endtask

   logic [15:0] s0;

   initial begin
      rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
      slot(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      tick(); tick();
      chk_nop("rst", 0);
      chk_nop("rst", 1);
      chk("rst_even_word", out_even_full_instr, 32'd0);
      chk("rst_odd_dst", 32'(out_odd_reg_dst), 32'd0);
      chk("rst_stall", 32'(stall_count), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      tick();

      // independent pair
      slot(0, 1, 0, 7'd5, 4'd2, 1, 7'd3, 7'd1, 7'd2, 3'b110, 32'h1111_1111);
      slot(1, 1, 1, 7'd9, 4'd6, 1, 7'd4, 7'd5, 7'd0, 3'b100, 32'h2222_2222);
      in_valid = 1'b1;
      settle();
      chk("indep_ready", 32'(in_ready), 32'd1);
      tick();
      chk("indep_even_id", 32'(out_even_instr_id), 32'd5);
      chk("indep_even_dst", 32'(out_even_reg_dst), 32'd3);
      chk("indep_even_word", out_even_full_instr, 32'h1111_1111);
      chk("indep_even_rb", 32'(out_even_rb_addr), 32'd2);
      chk("indep_odd_id", 32'(out_odd_instr_id), 32'd9);
      chk("indep_odd_dst", 32'(out_odd_reg_dst), 32'd4);
      chk("indep_odd_lat", 32'(out_odd_latency), 32'd6);
      chk("indep_odd_unit", 32'(out_odd_unit_id), 32'd2);
      chk("indep_cnt3", 32'(dut.cnt_q[3]), 32'd2);
      chk("indep_cnt4", 32'(dut.cnt_q[4]), 32'd6);

      // RAW on r4 (latency 6): five stall cycles
      slot(0, 1, 1, 7'd12, 4'd1, 1, 7'd20, 7'd4, 7'd0, 3'b100, 32'h3333_3333);
      slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      for (int k = 0; k < 5; k++) begin
         settle();
         chk($sformatf("raw_ready_%0d", k), 32'(in_ready), 32'd0);
         tick();
         chk_nop($sformatf("raw_hold_%0d", k), 1);
      end
      settle();
      chk("raw_ready_go", 32'(in_ready), 32'd1);
      tick();
      chk("raw_odd_id", 32'(out_odd_instr_id), 32'd12);
      chk_nop("raw_issue", 0);
      chk("raw_stall", 32'(stall_count), 32'd5);

      // same-pipe pair: slot1 defers one cycle
      slot(0, 1, 0, 7'd7, 4'd1, 1, 7'd11, 0, 0, 3'b000, 32'h4444_4444);
      slot(1, 1, 0, 7'd8, 4'd1, 1, 7'd12, 0, 0, 3'b000, 32'h5555_5555);
      settle();
      chk("same_ready_n", 32'(in_ready), 32'd0);
      tick();
      chk("same_even_id0", 32'(out_even_instr_id), 32'd7);
      chk_nop("same_n1", 1);
      chk("same_ready_n1", 32'(in_ready), 32'd1);
      tick();
      chk("same_even_id1", 32'(out_even_instr_id), 32'd8);
      chk("same_even_word", out_even_full_instr, 32'h5555_5555);
      chk("same_stall", 32'(stall_count), 32'd6);

      // intra-pair RAW on r10 (latency 3)
      slot(0, 1, 0, 7'd3, 4'd3, 1, 7'd10, 0, 0, 3'b000, 32'h6666_6666);
      slot(1, 1, 1, 7'd4, 4'd1, 1, 7'd13, 7'd10, 0, 3'b100, 32'h7777_7777);
      settle();
      chk("intra_ready_n", 32'(in_ready), 32'd0);
      tick();
      chk("intra_even_id", 32'(out_even_instr_id), 32'd3);
      chk_nop("intra_n1", 1);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("intra_ready_w%0d", k), 32'(in_ready), 32'd0);
         tick();
         chk_nop($sformatf("intra_wait_%0d", k), 1);
      end
      chk("intra_ready_go", 32'(in_ready), 32'd1);
      tick();
      chk("intra_odd_id", 32'(out_odd_instr_id), 32'd4);
      chk_nop("intra_issue", 0);
      chk("intra_stall", 32'(stall_count), 32'd9);

      // flush while slot1 is pending
      slot(0, 1, 0, 7'd21, 4'd5, 1, 7'd30, 0, 0, 3'b000, 32'h8888_8888);
      slot(1, 1, 1, 7'd22, 4'd1, 1, 7'd31, 0, 7'd30, 3'b010, 32'h9999_9999);
      tick();
      chk("fl_even_id", 32'(out_even_instr_id), 32'd21);
      chk("fl_cnt30", 32'(dut.cnt_q[30]), 32'd5);
      s0 = stall_count;
      flush = 1'b1;
      settle();
      chk("fl_ready", 32'(in_ready), 32'd1);
      tick();
      chk_nop("fl_out", 0);
      chk_nop("fl_out", 1);
      chk("fl_cnt30_dec", 32'(dut.cnt_q[30]), 32'd4);
      chk("fl_stall", 32'(stall_count), 32'(s0));
      flush = 1'b0;
      slot(0, 1, 0, 7'd40, 4'd1, 1, 7'd40, 0, 0, 3'b000, 32'hAAAA_AAAA);
      slot(1, 1, 1, 7'd41, 4'd1, 1, 7'd41, 0, 0, 3'b000, 32'hBBBB_BBBB);
      settle();
      chk("fl_pair_ready", 32'(in_ready), 32'd1);
      tick();
      chk("fl_pair_even", 32'(out_even_instr_id), 32'd40);
      chk("fl_pair_odd", 32'(out_odd_instr_id), 32'd41);

      // reset in the middle of a RAW stall
      slot(0, 1, 1, 7'd50, 4'd6, 1, 7'd4, 0, 0, 3'b000, 32'hCCCC_CCCC);
      slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      tick();
      chk("rs_prod_odd", 32'(out_odd_instr_id), 32'd50);
      slot(0, 1, 0, 7'd51, 4'd1, 1, 7'd60, 7'd4, 0, 3'b100, 32'hDDDD_DDDD);
      tick();
      chk("rs_cnt4", 32'(dut.cnt_q[4]), 32'd5);
      chk_nop("rs_hold", 0);
      rst = 1'b0;
      tick();
      chk("rs_cnt4_clr", 32'(dut.cnt_q[4]), 32'd0);
      chk_nop("rs_out", 0);
      chk_nop("rs_out", 1);
      chk("rs_stall", 32'(stall_count), 32'd0);
      rst = 1'b1;
      settle();
      chk("rs_ready", 32'(in_ready), 32'd1);
      tick();
      chk("rs_even_id", 32'(out_even_instr_id), 32'd51);

      // idle cycle: NOP outputs
      in_valid = 1'b0;
      settle();
      chk("idle_ready", 32'(in_ready), 32'd0);
      tick();
      chk_nop("idle", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
